dnn_pingpong_batch_ctrl: RTL and testbench
==========================================

Name: dnn_pingpong_batch_ctrl

Overview:
Parametrised successor to the single-buffered batch controller. It manages NBANK ping-pong banks of src/dst buffer so that three things overlap: loading sample n+1 from the source stream, computing sample n in the core array, and draining sample n-1 to the destination stream. It sits between the src/dst streaming ports, the banked src_buf/dst_buf, and sample_ctrl (s_init/s_fin).

Parameters:
NBANK, 2, number of buffer banks; power of two, 2..4
AW, 12, word address width within one bank
BW, (NBANK>2)?2:1, bank index width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
run  in  1  enable; low = synchronous abort to reset state
ss  in  AW  last src word address per sample (word count - 1)
ds  in  AW  last dst word address per sample (word count - 1)
src_valid  in  1  source stream valid
src_last  in  1  source stream last
src_ready  out  1  source stream ready
src_v  out  1  src_buf write enable
src_a  out  AW  src_buf write address
src_bank  out  BW  src_buf bank being written
s_init  out  1  one-cycle pulse: start a sample in sample_ctrl
s_bank  out  BW  bank computed (src read / dst write); valid from s_init until s_fin
s_fin  in  1  one-cycle pulse: sample compute complete
dst_v  out  1  dst_buf read enable
dst_a  out  AW  dst_buf read address
dst_bank  out  BW  dst_buf bank being read
dst_valid  out  1  destination stream valid (dst_data comes from the dst_buf registered output)
dst_last  out  1  destination stream last
dst_ready  in  1  destination stream ready

Behaviour:
- Reset (rst_n=0 at posedge) or run=0: all banks FREE; load/compute/drain pointers = 0; counters = 0. Outputs: src_ready=0, src_v=0, s_init=0, dst_v=0, dst_valid=0, dst_last=0. src_a/dst_a/s_bank/src_bank/dst_bank = 0.
- Per-bank state: FREE -> LOADED -> BUSY -> DONE -> FREE.
- Pointers lp, cp, dp advance round-robin modulo NBANK, each only on completion of its phase.
- Load: src_ready = run & state[lp]==FREE (combinational). src_v = src_valid & src_ready; src_a = load counter; src_bank = lp. Counter increments on each beat. On the beat with src_a==ss: bank becomes LOADED, counter returns to 0, lp advances. The next beat may be accepted the following cycle if the next bank is FREE.
- Compute: when state[cp]==LOADED and no bank is BUSY, s_init pulses for 1 cycle. In the same cycle s_bank<=cp and the bank becomes BUSY. On s_fin the BUSY bank becomes DONE and cp advances; s_init for the next bank no earlier than the cycle after s_fin. s_fin with no BUSY bank is ignored. s_init and s_fin never coincide on the same bank.
- Drain: active while state[dp]==DONE. dst_v = active & (dst_ready | ~dst_valid); dst_a = drain counter; dst_bank = dp. Read latency is 1 cycle.
  - dst_valid <= dst_v | (dst_valid & ~dst_ready).
  - dst_last <= (dst_v & dst_a==ds) | (dst_last & ~dst_ready).
  - Counter increments on dst_v. On dst_v with dst_a==ds: bank becomes FREE, counter returns to 0, dp advances.
  - Data is held stable while dst_valid & ~dst_ready.
- Simultaneous events are legal in one cycle: a load completing into bank i, a drain freeing bank j, and s_fin on bank k. A bank freed by drain is loadable next cycle, never the same cycle.
- Full: all banks non-FREE -> src_ready=0. Empty: no DONE bank -> dst_v=0.
- ss=0 / ds=0: single-word samples; completion on the first beat.
- Abort mid-operation (run=0 or reset): in-flight data is discarded and any partially emitted dst packet is truncated. sample_ctrl must also be reset by run=0.

Optional Feature:
DNN_PP_LASTCHK_EN:
- With it: adds output err (1 bit, sticky, reset 0, cleared by run=0). err is set on an accepted src beat where src_last != (src_a==ss). Loading still terminates on the counter.
- Without it: src_last is ignored and there is no err port.

Test Plan:
- NBANK=2, ss=3, ds=1, dst_ready=1, one sample of 4 beats -> src_a 0..3 on bank0; s_init 1 cycle after the 4th beat with s_bank=0; after s_fin, dst_valid for 2 beats, dst_last on the 2nd; bank0 FREE.
- NBANK=2, 3 back-to-back samples, s_fin 20 cycles after s_init -> sample1 loads into bank1 during compute of bank0; sample2 load stalls (src_ready=0) until bank0 drains.
- dst_ready toggling 1,0,0,1 during drain with ds=4 -> no beat lost or duplicated; addresses emitted 0..4 in order; dst_last only with word 4.
- run dropped mid-load (after 2 of 4 beats), then reasserted -> src_ready=0 in the abort cycle; the next sample starts at src_a=0, bank0.
- NBANK=4, 4 samples with the drain held off (dst_ready=0) -> all 4 banks fill; src_ready=0 on the 5th sample; the first drain beat frees bank0 after ds+1 reads.
- DNN_PP_LASTCHK_EN, ss=3, src_last on the 3rd beat -> err=1 and stays 1; run=0 clears it.

Source files
------------

// File: rtl/dnn_pingpong_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dnn_pingpong_batch_ctrl
// Desc     : NBANK ping-pong src/dst bank sequencer overlapping load, compute
//            and drain. Define DNN_PP_LASTCHK_EN to add the src_last check (err).
// Revision : 1.0  initial release
// ============================================================================
module dnn_pingpong_batch_ctrl #(
    parameter int NBANK = 2,
    parameter int AW    = 12,
    parameter int BW    = (NBANK > 2) ? 2 : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [AW-1:0] ss,
    input  logic [AW-1:0] ds,
    input  logic          src_valid,
    input  logic          src_last,
    output logic          src_ready,
    output logic          src_v,
    output logic [AW-1:0] src_a,
    output logic [BW-1:0] src_bank,
    output logic          s_init,
    output logic [BW-1:0] s_bank,
    input  logic          s_fin,
    output logic          dst_v,
    output logic [AW-1:0] dst_a,
    output logic [BW-1:0] dst_bank,
    output logic          dst_valid,
    output logic          dst_last,
`ifdef DNN_PP_LASTCHK_EN
    output logic          err,
`endif
    input  logic          dst_ready
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } bank_state_t;

    bank_state_t   r_state [NBANK];
    logic [BW-1:0] r_lp;
    logic [BW-1:0] r_cp;
    logic [BW-1:0] r_dp;
    logic [AW-1:0] r_lcnt;
    logic [AW-1:0] r_dcnt;
    logic          r_s_init;
    logic [BW-1:0] r_s_bank;
    logic          r_dst_valid;
    logic          r_dst_last;

    logic          w_en;
    logic          w_load_done;
    logic          w_start;
    logic          w_fin;
    logic          w_drain_act;
    logic          w_drain_done;

    assign w_en         = rst_n && run;

    assign src_ready    = w_en && (r_state[r_lp] == ST_FREE);
    assign src_v        = src_valid && src_ready;
    assign src_a        = r_lcnt;
    assign src_bank     = r_lp;
    assign w_load_done  = src_v && (r_lcnt == ss);

    // Only the compute pointer's bank can ever be BUSY, so checking cp alone
    // is equivalent to "no bank is BUSY".
    assign w_start      = (r_state[r_cp] == ST_LOADED);
    assign w_fin        = s_fin && (r_state[r_cp] == ST_BUSY);

    assign w_drain_act  = r_state[r_dp] == ST_DONE;
    assign dst_v        = w_en && w_drain_act && (dst_ready || !r_dst_valid);
    assign dst_a        = r_dcnt;
    assign dst_bank     = r_dp;
    assign w_drain_done = dst_v && (r_dcnt == ds);

    assign s_init       = r_s_init;
    assign s_bank       = r_s_bank;
    assign dst_valid    = r_dst_valid;
    assign dst_last     = r_dst_last;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            for (int i = 0; i < NBANK; i++) begin
                r_state[i] <= ST_FREE;
            end
            r_lp        <= '0;
            r_cp        <= '0;
            r_dp        <= '0;
            r_lcnt      <= '0;
            r_dcnt      <= '0;
            r_s_init    <= 1'b0;
            r_s_bank    <= '0;
            r_dst_valid <= 1'b0;
            r_dst_last  <= 1'b0;
        end else begin
            r_s_init <= 1'b0;

            if (src_v) begin
                if (w_load_done) begin
                    r_lcnt          <= '0;
                    r_state[r_lp]   <= ST_LOADED;
                    r_lp            <= r_lp + 1'b1;
                end else begin
                    r_lcnt          <= r_lcnt + 1'b1;
                end
            end

            // Load, start/finish and drain always touch distinct banks, so
            // these per-bank updates never collide within one cycle.
            if (w_start) begin
                r_s_init        <= 1'b1;
                r_s_bank        <= r_cp;
                r_state[r_cp]   <= ST_BUSY;
            end

            if (w_fin) begin
                r_state[r_cp]   <= ST_DONE;
                r_cp            <= r_cp + 1'b1;
            end

            if (dst_v) begin
                if (w_drain_done) begin
                    r_dcnt          <= '0;
                    r_state[r_dp]   <= ST_FREE;
                    r_dp            <= r_dp + 1'b1;
                end else begin
                    r_dcnt          <= r_dcnt + 1'b1;
                end
            end

            r_dst_valid <= dst_v || (r_dst_valid && !dst_ready);
            r_dst_last  <= w_drain_done || (r_dst_last && !dst_ready);
        end
    end

`ifdef DNN_PP_LASTCHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            r_err <= 1'b0;
        end else if (src_v && (src_last != (r_lcnt == ss))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_src_last;
    assign w_unused_src_last = src_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dnn_pingpong_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_pingpong_batch_ctrl
// Desc     : Directed self-checking bench for dnn_pingpong_batch_ctrl (2 and 4 banks).
// Revision : 1.0  initial release
// ============================================================================
module tb_dnn_pingpong_batch_ctrl;

    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          run;
    logic [AW-1:0] ss;
    logic [AW-1:0] ds;
    logic          src_valid;
    logic          src_last;
    logic          s_fin;
    logic          dst_ready;

    logic          src_ready, src_v, s_init, dst_v, dst_valid, dst_last;
    logic [AW-1:0] src_a, dst_a;
    logic [0:0]    src_bank, s_bank, dst_bank;

    logic          src_ready4, src_v4, s_init4, dst_v4, dst_valid4, dst_last4;
    logic [AW-1:0] src_a4, dst_a4;
    logic [1:0]    src_bank4, s_bank4, dst_bank4;

`ifdef DNN_PP_LASTCHK_EN
    logic          err, err4;
`endif

    int checks   = 0;
    int failures = 0;

    dnn_pingpong_batch_ctrl #(.NBANK(2), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ss(ss), .ds(ds),
        .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
        .src_v(src_v), .src_a(src_a), .src_bank(src_bank),
        .s_init(s_init), .s_bank(s_bank), .s_fin(s_fin),
        .dst_v(dst_v), .dst_a(dst_a), .dst_bank(dst_bank),
        .dst_valid(dst_valid), .dst_last(dst_last),
`ifdef DNN_PP_LASTCHK_EN
        .err(err),
`endif
        .dst_ready(dst_ready)
    );

    dnn_pingpong_batch_ctrl #(.NBANK(4), .AW(AW)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .ss(ss), .ds(ds),
        .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready4),
        .src_v(src_v4), .src_a(src_a4), .src_bank(src_bank4),
        .s_init(s_init4), .s_bank(s_bank4), .s_fin(s_fin),
        .dst_v(dst_v4), .dst_a(dst_a4), .dst_bank(dst_bank4),
        .dst_valid(dst_valid4), .dst_last(dst_last4),
`ifdef DNN_PP_LASTCHK_EN
        .err(err4),
`endif
        .dst_ready(dst_ready)
    );

    // Leaves the bench at a falling edge with rst_n released and run low.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; src_valid = 1'b0; src_last = 1'b0;
        s_fin = 1'b0; dst_ready = 1'b1; ss = '0; ds = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b1; src_valid = 1'b1; s_fin = 1'b0; dst_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL reset_src_ready got=%0b want=0", src_ready); end
        checks++; if (src_v !== 1'b0) begin failures++; $display("FAIL reset_src_v got=%0b want=0", src_v); end
        checks++; if (s_init !== 1'b0 || dst_v !== 1'b0) begin failures++; $display("FAIL reset_sinit_dstv got=%0b%0b want=00", s_init, dst_v); end
        checks++; if (dst_valid !== 1'b0 || dst_last !== 1'b0) begin failures++; $display("FAIL reset_dst got=%0b%0b want=00", dst_valid, dst_last); end
        checks++; if (src_a !== '0 || dst_a !== '0 || src_bank !== 1'b0 || s_bank !== 1'b0 || dst_bank !== 1'b0)
            begin failures++; $display("FAIL reset_addr src_a=%0d dst_a=%0d banks=%0d%0d%0d want=0", src_a, dst_a, src_bank, s_bank, dst_bank); end
        src_valid = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        ss = 12'd3; ds = 12'd1; dst_ready = 1'b1; run = 1'b1; src_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (src_v !== 1'b1 || src_a !== AW'(k) || src_bank !== 1'b0)
                begin failures++; $display("FAIL single_load beat=%0d got v=%0b a=%0d bank=%0d want v=1 a=%0d bank=0", k, src_v, src_a, src_bank, k); end
            @(negedge clk);
        end
        src_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_init === 1'b1) begin lat = c; break; end
            @(negedge clk);
        end
        checks++; if (lat < 0) begin failures++; $display("FAIL single_sinit got=none want=pulse"); end
        checks++; if (s_bank !== 1'b0) begin failures++; $display("FAIL single_sbank got=%0d want=0", s_bank); end
        @(negedge clk); #1;
        checks++; if (s_init !== 1'b0 || dst_v !== 1'b0) begin failures++; $display("FAIL single_pulse s_init=%0b dst_v=%0b want=00", s_init, dst_v); end
        @(negedge clk); s_fin = 1'b1;
        @(negedge clk); s_fin = 1'b0; #1;
        checks++; if (dst_v !== 1'b1 || dst_a !== 12'd0 || dst_bank !== 1'b0 || dst_valid !== 1'b0)
            begin failures++; $display("FAIL single_drain0 got v=%0b a=%0d bank=%0d valid=%0b want 1 0 0 0", dst_v, dst_a, dst_bank, dst_valid); end
        @(negedge clk); #1;
        checks++; if (dst_v !== 1'b1 || dst_a !== 12'd1 || dst_valid !== 1'b1 || dst_last !== 1'b0)
            begin failures++; $display("FAIL single_drain1 got v=%0b a=%0d valid=%0b last=%0b want 1 1 1 0", dst_v, dst_a, dst_valid, dst_last); end
        @(negedge clk); #1;
        checks++; if (dst_v !== 1'b0 || dst_valid !== 1'b1 || dst_last !== 1'b1)
            begin failures++; $display("FAIL single_drain2 got v=%0b valid=%0b last=%0b want 0 1 1", dst_v, dst_valid, dst_last); end
        @(negedge clk); #1;
        checks++; if (dst_valid !== 1'b0 || dst_last !== 1'b0)
            begin failures++; $display("FAIL single_drain3 got valid=%0b last=%0b want 0 0", dst_valid, dst_last); end
        // One-word samples: bank1 then bank0, proving bank0 was released.
        @(negedge clk); ss = 12'd0; src_valid = 1'b1; #1;
        checks++; if (src_v !== 1'b1 || src_bank !== 1'b1) begin failures++; $display("FAIL single_next1 got v=%0b bank=%0d want 1 1", src_v, src_bank); end
        @(negedge clk); #1;
        checks++; if (src_v !== 1'b1 || src_bank !== 1'b0 || src_a !== 12'd0)
            begin failures++; $display("FAIL single_bank0_free got v=%0b bank=%0d a=%0d want 1 0 0", src_v, src_bank, src_a); end
        @(negedge clk); src_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int beats, fin_at, fin1, d0, stall, nsi, hs, nlast;
        int bcyc [12];
        logic [0:0] bbank [12];
        int sicyc [3];
        logic [0:0] sibank [3];
        beats = 0; fin_at = -1; fin1 = -1; d0 = -1; stall = 0; nsi = 0; hs = 0; nlast = 0;
        do_reset();
        ss = 12'd3; ds = 12'd1; dst_ready = 1'b1; run = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            src_valid = (beats < 12);
            s_fin = (cyc == fin_at);
            #1;
            if (s_fin && fin1 < 0) fin1 = cyc;
            if (beats == 8 && !src_ready) stall++;
            if (src_v && beats < 12) begin bcyc[beats] = cyc; bbank[beats] = src_bank; beats++; end
            if (s_init) begin
                if (nsi < 3) begin sicyc[nsi] = cyc; sibank[nsi] = s_bank; end
                nsi++;
                fin_at = cyc + 20;
            end
            if (dst_v && dst_bank == 1'b0 && dst_a == ds && d0 < 0) d0 = cyc;
            if (dst_valid && dst_ready) begin hs++; if (dst_last) nlast++; end
            @(negedge clk);
        end
        src_valid = 1'b0; s_fin = 1'b0;
        checks++; if (beats != 12) begin failures++; $display("FAIL b2b_beats got=%0d want=12", beats); end
        if (beats == 12) begin
            for (int i = 0; i < 12; i++) begin
                checks++; if (bbank[i] !== 1'((i / 4) % 2)) begin failures++; $display("FAIL b2b_bank beat=%0d got=%0d want=%0d", i, bbank[i], (i / 4) % 2); end
            end
            checks++; if (!(bcyc[7] < fin1)) begin failures++; $display("FAIL b2b_overlap load1_end=%0d fin0=%0d want load1_end<fin0", bcyc[7], fin1); end
            checks++; if (d0 < 0 || bcyc[8] != d0 + 1) begin failures++; $display("FAIL b2b_reload got beat8=%0d want=%0d", bcyc[8], d0 + 1); end
            checks++; if (stall != d0 - bcyc[7] || stall < 1) begin failures++; $display("FAIL b2b_stall got=%0d want=%0d", stall, d0 - bcyc[7]); end
        end
        checks++; if (nsi != 3) begin failures++; $display("FAIL b2b_sinit_count got=%0d want=3", nsi); end
        if (nsi == 3) begin
            checks++; if (sibank[0] !== 1'b0 || sibank[1] !== 1'b1 || sibank[2] !== 1'b0)
                begin failures++; $display("FAIL b2b_sbank got=%0d%0d%0d want=010", sibank[0], sibank[1], sibank[2]); end
            checks++; if (!(sicyc[1] > fin1)) begin failures++; $display("FAIL b2b_sinit_after_fin got=%0d want>%0d", sicyc[1], fin1); end
        end
        checks++; if (hs != 6 || nlast != 3) begin failures++; $display("FAIL b2b_drain got words=%0d lasts=%0d want 6 3", hs, nlast); end
    endtask

    task automatic test_backpressure();
        int fin_at, k;
        logic [3:0]    pat;
        logic [AW-1:0] held;
        fin_at = -1; k = 0; pat = 4'b1001; held = '0;
        do_reset();
        ss = 12'd0; ds = 12'd4; run = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            src_valid = (cyc == 0);
            s_fin = (cyc == fin_at);
            dst_ready = pat[cyc % 4];
            #1;
            if (s_init) fin_at = cyc + 5;
            if (dst_valid && dst_ready) begin
                checks++; if (held !== AW'(k)) begin failures++; $display("FAIL bp_word got=%0d want=%0d", held, k); end
                checks++; if (dst_last !== (k == 4)) begin failures++; $display("FAIL bp_last word=%0d got=%0b want=%0b", k, dst_last, k == 4); end
                k++;
            end
            if (dst_valid && !dst_ready && dst_v) begin
                checks++; failures++; $display("FAIL bp_hold got dst_v=1 while stalled want=0");
            end
            if (dst_v) held = dst_a;
            @(negedge clk);
        end
        src_valid = 1'b0; s_fin = 1'b0; dst_ready = 1'b1;
        checks++; if (k != 5) begin failures++; $display("FAIL bp_count got=%0d want=5", k); end
        #1;
        checks++; if (dst_valid !== 1'b0) begin failures++; $display("FAIL bp_idle got valid=%0b want=0", dst_valid); end
    endtask

    task automatic test_abort();
        do_reset();
        ss = 12'd3; ds = 12'd1; run = 1'b1; src_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 4) begin
                checks++; if (src_bank !== 1'b1 || src_a !== 12'd0) begin failures++; $display("FAIL abort_pre got bank=%0d a=%0d want 1 0", src_bank, src_a); end
            end
            @(negedge clk);
        end
        run = 1'b0; #1;
        checks++; if (src_ready !== 1'b0 || src_v !== 1'b0 || dst_v !== 1'b0)
            begin failures++; $display("FAIL abort_cycle got ready=%0b v=%0b dst_v=%0b want 000", src_ready, src_v, dst_v); end
        @(negedge clk); run = 1'b1; #1;
        checks++; if (src_ready !== 1'b1 || src_a !== 12'd0 || src_bank !== 1'b0 || s_init !== 1'b0)
            begin failures++; $display("FAIL abort_restart got ready=%0b a=%0d bank=%0d s_init=%0b want 1 0 0 0", src_ready, src_a, src_bank, s_init); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) #1;
            checks++; if (src_v !== 1'b1 || src_a !== AW'(k) || src_bank !== 1'b0)
                begin failures++; $display("FAIL abort_reload beat=%0d got a=%0d bank=%0d want a=%0d bank=0", k, src_a, src_bank, k); end
            @(negedge clk);
        end
        src_valid = 1'b0;
    endtask

    task automatic test_full4();
        int beats, fin_at, rd0;
        logic freed;
        logic [1:0] bb [8];
        beats = 0; fin_at = -1; rd0 = 0; freed = 1'b0;
        do_reset();
        ss = 12'd1; ds = 12'd2; dst_ready = 1'b0; run = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            src_valid = 1'b1;
            s_fin = (cyc == fin_at);
            #1;
            if (src_v4) begin if (beats < 8) bb[beats] = src_bank4; beats++; end
            if (dst_v4 && dst_bank4 == 2'd0) rd0++;
            if (s_init4) fin_at = cyc + 3;
            @(negedge clk);
        end
        s_fin = 1'b0; #1;
        checks++; if (beats != 8) begin failures++; $display("FAIL full4_beats got=%0d want=8", beats); end
        for (int i = 0; i < 8 && i < beats; i++) begin
            checks++; if (bb[i] !== 2'(i / 2)) begin failures++; $display("FAIL full4_bank beat=%0d got=%0d want=%0d", i, bb[i], i / 2); end
        end
        checks++; if (src_ready4 !== 1'b0) begin failures++; $display("FAIL full4_ready got=%0b want=0", src_ready4); end
        checks++; if (rd0 != 1) begin failures++; $display("FAIL full4_stalled_reads got=%0d want=1", rd0); end
        @(negedge clk);
        for (int cyc = 0; cyc < 30; cyc++) begin
            dst_ready = 1'b1;
            #1;
            if (src_ready4) begin
                freed = 1'b1;
                checks++; if (src_bank4 !== 2'd0) begin failures++; $display("FAIL full4_free_bank got=%0d want=0", src_bank4); end
                checks++; if (rd0 != 3) begin failures++; $display("FAIL full4_free_reads got=%0d want=3", rd0); end
                break;
            end
            if (dst_v4 && dst_bank4 == 2'd0) rd0++;
            @(negedge clk);
        end
        checks++; if (!freed) begin failures++; $display("FAIL full4_freed got=0 want=1"); end
        @(negedge clk);
        src_valid = 1'b0;
    endtask

`ifdef DNN_PP_LASTCHK_EN
    task automatic test_lastchk();
        do_reset();
        ss = 12'd3; ds = 12'd1; run = 1'b1; src_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src_last = (k == 2);
            #1;
            checks++; if (err !== (k == 3)) begin failures++; $display("FAIL lastchk_err beat=%0d got=%0b want=%0b", k, err, k == 3); end
            @(negedge clk);
        end
        src_valid = 1'b0; src_last = 1'b0;
        #1;
        checks++; if (src_bank !== 1'b1) begin failures++; $display("FAIL lastchk_counter got bank=%0d want=1", src_bank); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL lastchk_sticky got=%0b want=1", err); end
        @(negedge clk); run = 1'b0;
        @(negedge clk); run = 1'b1; #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL lastchk_clear got=%0b want=0", err); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; run = 1'b0; ss = '0; ds = '0; src_valid = 1'b0;
        src_last = 1'b0; s_fin = 1'b0; dst_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_full4();
`ifdef DNN_PP_LASTCHK_EN
        test_lastchk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
